// File: rtl/rvv_wb_pkg.sv
// Shared types and constants for the RVV asynchronous writeback arbiter.
//   WB_FIFO_DEPTH : entries per lane buffer (pointers are 1 bit wide)
//   WAIT_CNT_W    : width of the per-lane starvation wait counter
//   WbBeatT       : default {addr, data} beat for the standard 5/32 register file
//   wait_next()   : saturating wait-counter update shared by both lanes
package rvv_wb_pkg;

    localparam int unsigned WB_FIFO_DEPTH = 2;
    localparam int unsigned WAIT_CNT_W    = 8;
    localparam int unsigned WB_ADDR_W     = 5;
    localparam int unsigned WB_DATA_W     = 32;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } WbBeatT;

    // Count cycles a buffered head is held off; any pop or an empty lane restarts it.
    function automatic logic [WAIT_CNT_W-1:0] wait_next(input logic [WAIT_CNT_W-1:0] cnt,
                                                        input logic                  blocked);
        if (!blocked) begin
            return '0;
        end
        return (cnt == {WAIT_CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/rvv_async_wb_arbiter_if.sv
// Bus bundle between the RVV async writeback ports / scalar core and the arbiter.
//   master : RVV beat producer plus scalar core (drives beats and core wb valids)
//   slave  : the arbiter (returns ready, XRF/FRF write ports, sb clears, stall, idle)
interface rvv_async_wb_arbiter_if
    import rvv_wb_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = WB_ADDR_W,
    parameter int unsigned REG_DATA_W = WB_DATA_W
);
    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

    logic                  async_rd_valid;
    logic [REG_ADDR_W-1:0] async_rd_addr;
    logic [REG_DATA_W-1:0] async_rd_data;
    logic                  async_rd_ready;
    logic                  async_frd_valid;
    logic [REG_ADDR_W-1:0] async_frd_addr;
    logic [REG_DATA_W-1:0] async_frd_data;
    logic                  async_frd_ready;
    logic                  core_xwb_valid;
    logic                  core_fwb_valid;
    logic                  xrf_wr_valid;
    logic [REG_ADDR_W-1:0] xrf_wr_addr;
    logic [REG_DATA_W-1:0] xrf_wr_data;
    logic                  frf_wr_valid;
    logic [REG_ADDR_W-1:0] frf_wr_addr;
    logic [REG_DATA_W-1:0] frf_wr_data;
    logic [NUM_REGS-1:0]   xrf_sb_clr;
    logic [NUM_REGS-1:0]   frf_sb_clr;
    logic                  core_wb_stall;
    logic                  wb_idle;

    modport master (
        output async_rd_valid, async_rd_addr, async_rd_data,
        output async_frd_valid, async_frd_addr, async_frd_data,
        output core_xwb_valid, core_fwb_valid,
        input  async_rd_ready, async_frd_ready,
        input  xrf_wr_valid, xrf_wr_addr, xrf_wr_data,
        input  frf_wr_valid, frf_wr_addr, frf_wr_data,
        input  xrf_sb_clr, frf_sb_clr, core_wb_stall, wb_idle
    );

    modport slave (
        input  async_rd_valid, async_rd_addr, async_rd_data,
        input  async_frd_valid, async_frd_addr, async_frd_data,
        input  core_xwb_valid, core_fwb_valid,
        output async_rd_ready, async_frd_ready,
        output xrf_wr_valid, xrf_wr_addr, xrf_wr_data,
        output frf_wr_valid, frf_wr_addr, frf_wr_data,
        output xrf_sb_clr, frf_sb_clr, core_wb_stall, wb_idle
    );

endinterface

// File: rtl/rvv_wb_skid.sv
// Two-entry in-order beat buffer for one writeback lane.
//   clk, rstn : clock, asynchronous active-low reset (control state only)
//   push      : write push_beat at the tail (caller guarantees ready)
//   pop       : drop the head (caller guarantees count > 0)
//   head      : current head entry, valid while count > 0
//   count     : occupancy 0..2
//   ready     : space available, derived from the registered count only
module rvv_wb_skid
    import rvv_wb_pkg::*;
#(
    parameter type BeatT = WbBeatT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  BeatT       push_beat,
    input  logic       pop,
    output BeatT       head,
    output logic [1:0] count,
    output logic       ready
);
    localparam logic [1:0] FULL = 2'(WB_FIFO_DEPTH);

    BeatT       mem [WB_FIFO_DEPTH];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Storage contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_beat;
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;
    assign ready = (count_q != FULL);

endmodule

// File: rtl/rvv_async_wb_arbiter.sv
// Merges the RVV asynchronous integer/fp writeback streams into the scalar XRF/FRF
// write ports. The scalar pipeline always wins the port; buffered beats that wait
// too long raise core_wb_stall so the pipeline yields a slot.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : slave side of rvv_async_wb_arbiter_if (beats, core wb valids,
//               write ports, scoreboard clears, stall request, idle flag)
module rvv_async_wb_arbiter
    import rvv_wb_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = WB_ADDR_W,
    parameter int unsigned REG_DATA_W   = WB_DATA_W,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    rvv_async_wb_arbiter_if.slave bus
);
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } LaneBeatT;

    // Stall is registered, so compare against LIMIT-1 to land exactly LIMIT cycles out.
    localparam logic [WAIT_CNT_W-1:0] STALL_THR = WAIT_CNT_W'(STARVE_LIMIT - 1);

    LaneBeatT              x_in, f_in, x_head, f_head;
    logic [1:0]            x_count, f_count;
    logic                  x_ready, f_ready;
    logic                  x_push, f_push, x_pop, f_pop;
    logic                  x_blocked, f_blocked;
    logic                  x_wr;
    logic [WAIT_CNT_W-1:0] x_wait_q, f_wait_q;
    logic                  stall_q, stall_d;

    assign x_in = '{addr: bus.async_rd_addr, data: bus.async_rd_data};
    assign f_in = '{addr: bus.async_frd_addr, data: bus.async_frd_data};

    assign x_push = bus.async_rd_valid && x_ready;
    assign f_push = bus.async_frd_valid && f_ready;
    assign x_pop  = (x_count != 2'd0) && !bus.core_xwb_valid;
    assign f_pop  = (f_count != 2'd0) && !bus.core_fwb_valid;

    assign x_blocked = (x_count != 2'd0) && !x_pop;
    assign f_blocked = (f_count != 2'd0) && !f_pop;

    rvv_wb_skid #(.BeatT(LaneBeatT)) u_x_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (x_push),
        .push_beat (x_in),
        .pop       (x_pop),
        .head      (x_head),
        .count     (x_count),
        .ready     (x_ready)
    );

    rvv_wb_skid #(.BeatT(LaneBeatT)) u_f_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (f_push),
        .push_beat (f_in),
        .pop       (f_pop),
        .head      (f_head),
        .count     (f_count),
        .ready     (f_ready)
    );

    // x0 is hardwired zero: its beats are popped and silently dropped.
    assign x_wr = x_pop && (x_head.addr != '0);

    always_comb begin
        bus.xrf_sb_clr = '0;
        bus.frf_sb_clr = '0;
        if (x_wr)  bus.xrf_sb_clr[x_head.addr] = 1'b1;
        if (f_pop) bus.frf_sb_clr[f_head.addr] = 1'b1;
    end

    assign bus.xrf_wr_valid = x_wr;
    assign bus.xrf_wr_addr  = x_head.addr;
    assign bus.xrf_wr_data  = x_head.data;
    assign bus.frf_wr_valid = f_pop;
    assign bus.frf_wr_addr  = f_head.addr;
    assign bus.frf_wr_data  = f_head.data;

    always_comb begin
        stall_d = (x_blocked && (x_wait_q >= STALL_THR)) ||
                  (f_blocked && (f_wait_q >= STALL_THR));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_wait_q <= '0;
            f_wait_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            x_wait_q <= wait_next(x_wait_q, x_blocked);
            f_wait_q <= wait_next(f_wait_q, f_blocked);
            stall_q  <= stall_d;
        end
    end

    assign bus.async_rd_ready  = x_ready;
    assign bus.async_frd_ready = f_ready;
    assign bus.core_wb_stall   = stall_q;
    assign bus.wb_idle         = (x_count == 2'd0) && (f_count == 2'd0);

endmodule

// File: tb/tb_rvv_async_wb_arbiter.sv
// Self-checking bench: per-cycle comparison against a queue-based model of the two
// writeback lanes, with directed scenarios followed by randomized traffic.
module tb_rvv_async_wb_arbiter;

    localparam int unsigned LIMIT = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    rvv_async_wb_arbiter_if #(.REG_ADDR_W(5), .REG_DATA_W(32)) bus ();

    rvv_async_wb_arbiter #(
        .REG_ADDR_W   (5),
        .REG_DATA_W   (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int   n_total = 0;
    int   n_bad   = 0;
    ent_t xq[$];
    ent_t fq[$];
    int   x_run = 0;
    int   f_run = 0;
    bit   exp_stall = 1'b0;
    int   x_seen = 0;
    int   f_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.async_rd_valid  = 1'b0;
        bus.async_rd_addr   = '0;
        bus.async_rd_data   = '0;
        bus.async_frd_valid = 1'b0;
        bus.async_frd_addr  = '0;
        bus.async_frd_data  = '0;
        bus.core_xwb_valid  = 1'b0;
        bus.core_fwb_valid  = 1'b0;
    endtask

    // Called just after a rising edge; asserts reset asynchronously and checks reset outputs.
    task automatic do_reset();
        drive_idle();
        rstn = 1'b0;
        #3;
        check("rst_rd_ready", bus.async_rd_ready, 1);
        check("rst_frd_ready", bus.async_frd_ready, 1);
        check("rst_xrf_wr_valid", bus.xrf_wr_valid, 0);
        check("rst_frf_wr_valid", bus.frf_wr_valid, 0);
        check("rst_xrf_sb_clr", bus.xrf_sb_clr, 0);
        check("rst_frf_sb_clr", bus.frf_sb_clr, 0);
        check("rst_stall", bus.core_wb_stall, 0);
        check("rst_wb_idle", bus.wb_idle, 1);
        xq.delete();
        fq.delete();
        x_run = 0;
        f_run = 0;
        exp_stall = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic xv, input logic [4:0] xa, input logic [31:0] xd,
                        input logic fv, input logic [4:0] fa, input logic [31:0] fd,
                        input logic cx, input logic cf);
        bit          x_pop, f_pop, x_wr, x_ok, f_ok;
        logic [31:0] clr;
        bus.async_rd_valid  = xv;
        bus.async_rd_addr   = xa;
        bus.async_rd_data   = xd;
        bus.async_frd_valid = fv;
        bus.async_frd_addr  = fa;
        bus.async_frd_data  = fd;
        bus.core_xwb_valid  = cx;
        bus.core_fwb_valid  = cf;
        #3;
        x_pop = (xq.size() > 0) && !cx;
        f_pop = (fq.size() > 0) && !cf;
        x_wr  = x_pop && (xq[0].a != 5'd0);
        x_ok  = xv && (xq.size() < 2);
        f_ok  = fv && (fq.size() < 2);

        check("rd_ready", bus.async_rd_ready, xq.size() < 2);
        check("frd_ready", bus.async_frd_ready, fq.size() < 2);
        check("xrf_wr_valid", bus.xrf_wr_valid, x_wr);
        check("frf_wr_valid", bus.frf_wr_valid, f_pop);
        clr = '0;
        if (x_wr) begin
            check("xrf_wr_addr", bus.xrf_wr_addr, xq[0].a);
            check("xrf_wr_data", bus.xrf_wr_data, xq[0].d);
            clr[xq[0].a] = 1'b1;
        end
        check("xrf_sb_clr", bus.xrf_sb_clr, clr);
        clr = '0;
        if (f_pop) begin
            check("frf_wr_addr", bus.frf_wr_addr, fq[0].a);
            check("frf_wr_data", bus.frf_wr_data, fq[0].d);
            clr[fq[0].a] = 1'b1;
        end
        check("frf_sb_clr", bus.frf_sb_clr, clr);
        check("core_wb_stall", bus.core_wb_stall, exp_stall);
        check("wb_idle", bus.wb_idle, (xq.size() == 0) && (fq.size() == 0));
        if (bus.xrf_wr_valid === 1'b1) x_seen++;
        if (bus.frf_wr_valid === 1'b1) f_seen++;

        // Stall is due once a head has sat blocked for LIMIT consecutive cycles.
        x_run = ((xq.size() > 0) && !x_pop) ? x_run + 1 : 0;
        f_run = ((fq.size() > 0) && !f_pop) ? f_run + 1 : 0;
        exp_stall = (x_run >= int'(LIMIT)) || (f_run >= int'(LIMIT));
        if (x_pop) void'(xq.pop_front());
        if (f_pop) void'(fq.pop_front());
        if (x_ok) xq.push_back('{a: xa, d: xd});
        if (f_ok) fq.push_back('{a: fa, d: fd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n, input logic cx, input logic cf);
        for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, cx, cf);
    endtask

    int base_x;
    int base_f;
    int busy;

    initial begin
        drive_idle();
        rstn = 1'b1;
        #1;
        do_reset();

        // Single beat to x5.
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 0);
        idle_steps(2, 0, 0);

        // Back-pressure: core holds the XRF port while three beats are offered.
        step(1, 5'd3, 32'h1111_0003, 0, 5'd0, 32'd0, 1, 0);
        step(1, 5'd4, 32'h1111_0004, 0, 5'd0, 32'd0, 1, 0);
        step(1, 5'd6, 32'h1111_0006, 0, 5'd0, 32'd0, 1, 0);
        idle_steps(3, 0, 0);

        // x0 is dropped, f0 is written.
        step(1, 5'd0, 32'hAAAA_0000, 1, 5'd0, 32'hBBBB_0000, 0, 0);
        idle_steps(2, 0, 0);

        // Starvation on the X lane, then release.
        step(1, 5'd7, 32'h5555_0007, 0, 5'd0, 32'd0, 1, 0);
        idle_steps(6, 1, 0);
        idle_steps(3, 0, 0);
        // Same on the F lane.
        step(0, 5'd0, 32'd0, 1, 5'd9, 32'h6666_0009, 0, 1);
        idle_steps(5, 0, 1);
        idle_steps(3, 0, 0);

        // Concurrency: both lanes streaming with the core idle.
        base_x = x_seen;
        base_f = f_seen;
        for (int i = 0; i < 20; i++) begin
            step(1, 5'(1 + (i % 31)), $urandom, 1, 5'(i), $urandom, 0, 0);
        end
        idle_steps(1, 0, 0);
        check("conc_x_writes", 64'(x_seen - base_x), 20);
        check("conc_f_writes", 64'(f_seen - base_f), 20);

        // Reset with two beats buffered.
        step(1, 5'd10, 32'h7777_000A, 1, 5'd11, 32'h7777_000B, 1, 1);
        step(1, 5'd12, 32'h7777_000C, 1, 5'd13, 32'h7777_000D, 1, 1);
        do_reset();
        base_x = x_seen;
        base_f = f_seen;
        idle_steps(3, 0, 0);
        check("post_rst_x_writes", 64'(x_seen - base_x), 0);
        check("post_rst_f_writes", 64'(f_seen - base_f), 0);

        // Randomized traffic with bursts of heavy core activity.
        busy = 0;
        for (int i = 0; i < 600; i++) begin
            if ((i % 24) == 0) busy = int'($urandom_range(0, 10));
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'(int'($urandom_range(0, 9)) < busy), 1'(int'($urandom_range(0, 9)) < busy));
            if (i == 300) do_reset();
        end
        idle_steps(4, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
